// File: rtl/image_loader.sv
// image_loader: streaming front end for the MNIST inference core.
// Accepts one frame of 8-bit pixels over a valid/ready byte stream, converts
// each byte to the 16-bit fixed-point pixel format, writes it into the image
// RAM, pulses the network start once the frame is complete and then blocks
// further input until the network reports done.

module image_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10,
  parameter int PIX_SHIFT  = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              start_net_o,
  input  logic              net_done_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic [15:0]       frame_count_o
);

  // Address of the final pixel of a frame.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  // A one-pixel frame completes on the very first byte.
  localparam bit SINGLE_PIXEL = (NUM_PIXELS == 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    LAUNCH,
    WAIT_NET
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               start_net_q, start_net_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic [15:0]        pix_conv;

  // Input is taken in the three streaming states; held low throughout reset.
  assign s_ready_o = rst_n_i &
                     ((state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN));
  assign accept    = s_valid_i & s_ready_o;

  // Widen the raw byte and shift it into the fixed-point position; the
  // upper bits that fall off the 16-bit word are simply dropped.
  always_comb begin
    logic [15:0] pix_wide;
    pix_wide = {8'h00, s_data_i};
    pix_conv = pix_wide << PIX_SHIFT;
  end

  // Next-state and next-output logic for the frame loader FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    start_net_d   = 1'b0;
    frame_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = pix_conv;
          if (SINGLE_PIXEL) begin
            if (s_last_i) begin
              state_d = LAUNCH;
            end else begin
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end
          end else if (s_last_i) begin
            // Frame ended on its first byte: report it and stay put.
            frame_err_d = 1'b1;
          end else begin
            idx_d   = ADDR_W'(1);
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = pix_conv;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (s_last_i) begin
              state_d = LAUNCH;
            end else begin
              // Frame too long: the last pixel is kept, the rest is dropped.
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end
          end else if (s_last_i) begin
            // Frame too short: abandon it, RAM keeps whatever was written.
            frame_err_d = 1'b1;
            idx_d       = '0;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      DRAIN: begin
        if (accept && s_last_i) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end

      LAUNCH: begin
        // Start is raised one cycle after the final write so the last pixel
        // is already in RAM when the network begins reading.
        start_net_d = 1'b1;
        state_d     = WAIT_NET;
      end

      WAIT_NET: begin
        if (net_done_i) begin
          frame_count_d = frame_count_q + 16'd1;
          idx_d         = '0;
          state_d       = IDLE;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      frame_count_q <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      start_net_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_count_q <= frame_count_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      start_net_q   <= start_net_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign start_net_o   = start_net_q;
  assign frame_err_o   = frame_err_q;
  assign busy_o        = busy_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_image_loader.sv
// Testbench for image_loader: table of whole-frame scenarios plus hand-written
// sequences for reset, spurious done and frame counter wrap.

module tb_image_loader;

   localparam int NUM_PIXELS = 784;
   localparam int ADDR_W     = 10;
   localparam int PIX_SHIFT  = 7;

   logic              clk = 1'b0;
   logic              rstN = 1'b0;
   logic [7:0]        sData = '0;
   logic              sValid = 1'b0;
   logic              sLast = 1'b0;
   logic              sReady;
   logic              wrEn;
   logic [ADDR_W-1:0] wrAddr;
   logic [15:0]       wrData;
   logic              startNet;
   logic              netDone = 1'b0;
   logic              busy;
   logic              frameErr;
   logic [15:0]       frameCount;

   always #5 clk = ~clk;

   image_loader #(
      .NUM_PIXELS(NUM_PIXELS),
      .ADDR_W(ADDR_W),
      .PIX_SHIFT(PIX_SHIFT)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rstN),
      .s_data_i(sData),
      .s_valid_i(sValid),
      .s_last_i(sLast),
      .s_ready_o(sReady),
      .wr_en_o(wrEn),
      .wr_addr_o(wrAddr),
      .wr_data_o(wrData),
      .start_net_o(startNet),
      .net_done_i(netDone),
      .busy_o(busy),
      .frame_err_o(frameErr),
      .frame_count_o(frameCount)
   );

   typedef struct {
      string name;
      int    nBytes;
      int    lastIdx;
      bit    throttle;
      int    expWrites;
      int    expErr;
      bit    expStart;
   } frameVec_t;

   int          checksTotal = 0;
   int          checksPassed = 0;
   int          cycleCount = 0;
   int          wrAddrQ[$];
   logic [15:0] wrDataQ[$];
   int          startCount = 0;
   int          errCount = 0;
   int          lastWrCycle = -1;
   int          startCycle = -1;
   logic [15:0] expCount = '0;

   // Observe the write port and pulses every falling edge, away from the active edge
   always @(negedge clk) begin
      cycleCount++;
      if (wrEn) begin
         wrAddrQ.push_back(int'(wrAddr));
         wrDataQ.push_back(wrData);
         lastWrCycle = cycleCount;
      end
      if (startNet) begin
         startCount++;
         startCycle = cycleCount;
      end
      if (frameErr) errCount++;
   end

   // Hard stop if something hangs the bench
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic clearMonitor();
      wrAddrQ.delete();
      wrDataQ.delete();
      startCount = 0;
      errCount = 0;
      lastWrCycle = -1;
      startCycle = -1;
   endtask

   function automatic logic [15:0] expPix(input int i);
      logic [15:0] w;
      w = 16'(i % 256);
      return w << PIX_SHIFT;
   endfunction

   // Present one byte at a falling edge and hold it until it has been taken
   task automatic sendByte(input logic [7:0] b, input bit last);
      int waited = 0;
      sData = b;
      sValid = 1'b1;
      sLast = last;
      while (!sReady && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!sReady) checkOutput("sReadyWait", 32'(sReady), 32'd1);
      else @(negedge clk);
      sValid = 1'b0;
      sLast = 1'b0;
   endtask

   // Stream bytes 0,1,2.. (mod 256) with s_last on lastIdx
   task automatic applyStimulus(input int nBytes, input int lastIdx, input bit throttle);
      for (int i = 0; i < nBytes; i++) begin
         sendByte(8'(i), (i == lastIdx));
         if (throttle) @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   // Compare everything the monitor saw against a scenario record
   task automatic checkFrame(input frameVec_t v);
      int badAddr = -1;
      int badData = -1;
      checkOutput({v.name, " writes"}, 32'(wrAddrQ.size()), 32'(v.expWrites));
      for (int i = 0; i < wrAddrQ.size(); i++) begin
         if (badAddr < 0 && wrAddrQ[i] != i) badAddr = i;
         if (badData < 0 && wrDataQ[i] !== expPix(i)) badData = i;
      end
      checkOutput({v.name, " firstBadAddrIdx"}, 32'(badAddr), 32'hFFFF_FFFF);
      checkOutput({v.name, " firstBadDataIdx"}, 32'(badData), 32'hFFFF_FFFF);
      if (wrDataQ.size() > 255) checkOutput({v.name, " pixFF"}, 32'(wrDataQ[255]), 32'h7F80);
      checkOutput({v.name, " frameErr"}, 32'(errCount), 32'(v.expErr));
      checkOutput({v.name, " startNet"}, 32'(startCount), v.expStart ? 32'd1 : 32'd0);
      if (v.expStart) begin
         checkOutput({v.name, " startTiming"}, 32'(startCycle), 32'(lastWrCycle + 1));
         checkOutput({v.name, " readyWait"}, 32'(sReady), 32'd0);
         repeat (4) @(negedge clk);
         checkOutput({v.name, " readyHeld"}, 32'(sReady), 32'd0);
         checkOutput({v.name, " busyHeld"}, 32'(busy), 32'd1);
         netDone = 1'b1;
         @(negedge clk);
         netDone = 1'b0;
         expCount = expCount + 16'd1;
         checkOutput({v.name, " readyAfterDone"}, 32'(sReady), 32'd1);
         checkOutput({v.name, " frameCount"}, 32'(frameCount), 32'(expCount));
         checkOutput({v.name, " startCountFinal"}, 32'(startCount), 32'd1);
      end else begin
         checkOutput({v.name, " idleBusy"}, 32'(busy), 32'd0);
         checkOutput({v.name, " idleReady"}, 32'(sReady), 32'd1);
         checkOutput({v.name, " frameCountKept"}, 32'(frameCount), 32'(expCount));
      end
      @(negedge clk);
   endtask

   frameVec_t vecs[7];
   frameVec_t fullVec;

   initial begin
      vecs[0] = '{"nominal",    784, 783, 1'b0, 784, 0, 1'b1};
      vecs[1] = '{"throttled",  784, 783, 1'b1, 784, 0, 1'b1};
      vecs[2] = '{"short",      100,  99, 1'b0, 100, 1, 1'b0};
      vecs[3] = '{"afterShort", 784, 783, 1'b0, 784, 0, 1'b1};
      vecs[4] = '{"long",       790, 789, 1'b0, 784, 1, 1'b0};
      vecs[5] = '{"oneByte",      1,   0, 1'b0,   1, 1, 1'b0};
      vecs[6] = '{"recover",    784, 783, 1'b0, 784, 0, 1'b1};
      fullVec = '{"postReset",  784, 783, 1'b0, 784, 0, 1'b1};

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rstReady", 32'(sReady), 32'd0);
      checkOutput("rstWrEn", 32'(wrEn), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstCount", 32'(frameCount), 32'd0);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("releaseReady", 32'(sReady), 32'd1);

      // Table of whole-frame scenarios
      for (int r = 0; r < 7; r++) begin
         clearMonitor();
         applyStimulus(vecs[r].nBytes, vecs[r].lastIdx, vecs[r].throttle);
         checkFrame(vecs[r]);
      end

      // Spurious done while loading, then reset at pixel 400
      clearMonitor();
      applyStimulus(200, -1, 1'b0);
      netDone = 1'b1;
      @(negedge clk);
      netDone = 1'b0;
      @(negedge clk);
      checkOutput("spuriousDoneCount", 32'(frameCount), 32'(expCount));
      checkOutput("spuriousDoneBusy", 32'(busy), 32'd1);
      for (int i = 200; i < 400; i++) sendByte(8'(i), 1'b0);
      rstN = 1'b0;
      #1;
      checkOutput("midRstWrEn", 32'(wrEn), 32'd0);
      checkOutput("midRstAddr", 32'(wrAddr), 32'd0);
      checkOutput("midRstData", 32'(wrData), 32'd0);
      checkOutput("midRstStart", 32'(startNet), 32'd0);
      checkOutput("midRstErr", 32'(frameErr), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstReady", 32'(sReady), 32'd0);
      checkOutput("midRstCount", 32'(frameCount), 32'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      expCount = '0;
      @(negedge clk);
      checkOutput("postRstReady", 32'(sReady), 32'd1);
      clearMonitor();
      applyStimulus(784, 783, 1'b0);
      checkFrame(fullVec);

      // Frame counter wrap
      force dut.frame_count_d = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_d;
      @(negedge clk);
      checkOutput("preloadCount", 32'(frameCount), 32'h0000_FFFF);
      expCount = 16'hFFFF;
      clearMonitor();
      applyStimulus(784, 783, 1'b0);
      fullVec.name = "wrap";
      checkFrame(fullVec);
      checkOutput("wrapCount", 32'(frameCount), 32'd0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
